// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response codes, slave FSM encoding and an
// address-range helper used by the data-memory slave.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRESP = 2'd1,
        ST_RRESP = 2'd2
    } state_t;

    // True when a byte offset lies past the last word of a DEPTH-word memory.
    function automatic logic offset_oob(input logic [31:0] offset, input int unsigned depth);
        logic [33:0] limit;
        limit = 34'(depth) << 2;
        return {2'b00, offset} >= limit;
    endfunction

endpackage

// File: rtl/dmem_sram_1rw.sv
// Single-port 32-bit SRAM with per-byte write enables and a registered read port.
// Contents are never reset.
module dmem_sram_1rw #(
    parameter int DEPTH = 1024
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic                     we,
    input  logic [3:0]               be,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) begin
                        mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                    end
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/axi4_lite_dmem_slave.sv
// AXI4-Lite slave in front of a single-port data memory, one transaction at a time.
// Optional macro DMEM_SLVERR_EN: out-of-range accesses answer SLVERR instead of aliasing.
module axi4_lite_dmem_slave
    import axi4_lite_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int          DEPTH     = 1024
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] S_AXI_AWADDR,
    input  logic [2:0]  S_AXI_AWPROT,
    input  logic        S_AXI_AWVALID,
    output logic        S_AXI_AWREADY,
    input  logic [31:0] S_AXI_WDATA,
    input  logic [3:0]  S_AXI_WSTRB,
    input  logic        S_AXI_WVALID,
    output logic        S_AXI_WREADY,
    output logic [1:0]  S_AXI_BRESP,
    output logic        S_AXI_BVALID,
    input  logic        S_AXI_BREADY,
    input  logic [31:0] S_AXI_ARADDR,
    input  logic [2:0]  S_AXI_ARPROT,
    input  logic        S_AXI_ARVALID,
    output logic        S_AXI_ARREADY,
    output logic [31:0] S_AXI_RDATA,
    output logic [1:0]  S_AXI_RRESP,
    output logic        S_AXI_RVALID,
    input  logic        S_AXI_RREADY
);

    localparam int IDX_W = $clog2(DEPTH);

    // Handshake: a channel transfers on a rising clk edge where VALID && READY.
    // Sources hold VALID and payload stable until that edge; READY never waits on
    // a later transfer, and this slave keeps B/R payload stable while VALID is high.

    state_t      state_q, state_d;
    logic        init_q;
    logic        aw_held_q, w_held_q;
    logic [31:0] aw_addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic [1:0]  bresp_q, rresp_q;
    logic        rerr_q;

    logic        aw_hs, w_hs, ar_hs, wr_fire;
    logic [31:0] wr_addr, wr_data, wr_off, rd_off;
    logic [3:0]  wr_strb;
    logic        wr_err, rd_err;
    logic [31:0] sram_rdata;
    logic        idle;

    assign idle          = init_q && (state_q == ST_IDLE);
    assign S_AXI_AWREADY = idle && !aw_held_q;
    assign S_AXI_WREADY  = idle && !w_held_q;
    // Reads also yield to write beats on the wire so a write and a read never
    // complete on the same edge of the single-port memory.
    assign S_AXI_ARREADY = idle && !aw_held_q && !w_held_q && !S_AXI_AWVALID && !S_AXI_WVALID;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    assign wr_addr = aw_held_q ? aw_addr_q : S_AXI_AWADDR;
    assign wr_data = w_held_q  ? wdata_q   : S_AXI_WDATA;
    assign wr_strb = w_held_q  ? wstrb_q   : S_AXI_WSTRB;
    assign wr_fire = idle && (aw_held_q || aw_hs) && (w_held_q || w_hs);

    assign wr_off = wr_addr - BASE_ADDR;
    assign rd_off = S_AXI_ARADDR - BASE_ADDR;

`ifdef DMEM_SLVERR_EN
    assign wr_err = offset_oob(wr_off, DEPTH);
    assign rd_err = offset_oob(rd_off, DEPTH);
`else
    assign wr_err = 1'b0;
    assign rd_err = 1'b0;
`endif

    dmem_sram_1rw #(.DEPTH(DEPTH)) u_sram (
        .clk   (clk),
        .en    ((wr_fire && !wr_err) || ar_hs),
        .we    (wr_fire),
        .be    (wr_strb),
        .addr  (wr_fire ? wr_off[IDX_W+1:2] : rd_off[IDX_W+1:2]),
        .wdata (wr_data),
        .rdata (sram_rdata)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (wr_fire)    state_d = ST_WRESP;
                else if (ar_hs) state_d = ST_RRESP;
            end
            ST_WRESP: if (S_AXI_BREADY) state_d = ST_IDLE;
            ST_RRESP: if (S_AXI_RREADY) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            init_q    <= 1'b0;
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
            aw_addr_q <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bresp_q   <= RESP_OKAY;
            rresp_q   <= RESP_OKAY;
            rerr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            init_q  <= 1'b1;
            if (wr_fire) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bresp_q   <= wr_err ? RESP_SLVERR : RESP_OKAY;
            end else begin
                if (aw_hs) begin
                    aw_held_q <= 1'b1;
                    aw_addr_q <= S_AXI_AWADDR;
                end
                if (w_hs) begin
                    w_held_q <= 1'b1;
                    wdata_q  <= S_AXI_WDATA;
                    wstrb_q  <= S_AXI_WSTRB;
                end
            end
            if (ar_hs) begin
                rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
                rerr_q  <= rd_err;
            end
        end
    end

    assign S_AXI_BVALID = (state_q == ST_WRESP);
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = (state_q == ST_RRESP);
    assign S_AXI_RRESP  = rresp_q;
    assign S_AXI_RDATA  = (S_AXI_RVALID && !rerr_q) ? sram_rdata : 32'h0;

    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, wr_off, rd_off};

endmodule
